// File: rtl/bcd_pkg.sv
// Shared types and constants for the sequential binary-to-BCD converter.
package bcd_pkg;

    // Converter control states: waiting for a request, or running iterations.
    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    // Width of one packed decimal digit.
    localparam int BCD_DIGIT_W = 4;

    // A digit at or above this value would overflow past 9 when doubled,
    // so it is pre-corrected before the shift.
    localparam logic [BCD_DIGIT_W-1:0] ADJ_THRESH = 4'd5;

    // Correction added to a digit that meets the threshold.
    localparam logic [BCD_DIGIT_W-1:0] ADJ_ADD = 4'd3;

endpackage

// File: rtl/bcd_digit_adj.sv
// Single-digit add-3 correction used by the shift-and-add-3 converter.
module bcd_digit_adj
    import bcd_pkg::*;
(
    input  logic [BCD_DIGIT_W-1:0] digit_i,
    output logic [BCD_DIGIT_W-1:0] digit_o
);

    // Add 3 to a digit of 5 or more so the following left shift carries
    // correctly into the next decimal digit; the 4-bit add drops any carry.
    always_comb begin
        digit_o = digit_i;
        if (digit_i >= ADJ_THRESH) begin
            digit_o = digit_i + ADJ_ADD;
        end
    end

endmodule

// File: rtl/bin_to_bcd_seq.sv
// Sequential binary-to-BCD converter: one adjust-and-shift iteration per
// clock, start/busy/done handshake, registered packed-BCD result.
module bin_to_bcd_seq
    import bcd_pkg::*;
#(
    parameter int W      = 8,
    parameter int DIGITS = 3
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          start,
    input  logic [W-1:0]                  bin_in,
    output logic                          busy,
    output logic                          done,
    output logic [BCD_DIGIT_W*DIGITS-1:0] bcd_out
);

    localparam int BCD_W = BCD_DIGIT_W * DIGITS;
    localparam int CNT_W = $clog2(W);
    localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(W - 1);

    state_t             state_q,    state_d;
    logic [W-1:0]       shiftReg_q, shiftReg_d;
    logic [BCD_W-1:0]   workBcd_q,  workBcd_d;
    logic [CNT_W-1:0]   iterCnt_q,  iterCnt_d;
    logic [BCD_W-1:0]   bcdOut_q,   bcdOut_d;
    logic               done_q,     done_d;

    logic [BCD_W-1:0]   adjBcd;
    logic [BCD_W+W-1:0] shiftedAll;
    logic [BCD_W-1:0]   shiftedBcd;
    logic [W-1:0]       shiftedBin;

    // One add-3 corrector per working digit.
    genvar g;
    generate
        for (g = 0; g < DIGITS; g++) begin : gen_adj
            bcd_digit_adj u_adj (
                .digit_i (workBcd_q[g*BCD_DIGIT_W +: BCD_DIGIT_W]),
                .digit_o (adjBcd[g*BCD_DIGIT_W +: BCD_DIGIT_W])
            );
        end
    endgenerate

    // Shift the corrected digits and the remaining binary bits left as one
    // word, so the binary MSB moves into the units digit LSB.
    always_comb begin
        shiftedAll = {adjBcd, shiftReg_q} << 1;
        shiftedBcd = shiftedAll[BCD_W+W-1:W];
        shiftedBin = shiftedAll[W-1:0];
    end

    // Next-state logic: load on an accepted request, iterate W times, then
    // publish the result with a one-cycle done pulse. The counter holds on
    // the final iteration instead of incrementing so it never wraps.
    always_comb begin
        state_d    = state_q;
        shiftReg_d = shiftReg_q;
        workBcd_d  = workBcd_q;
        iterCnt_d  = iterCnt_q;
        bcdOut_d   = bcdOut_q;
        done_d     = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    shiftReg_d = bin_in;
                    workBcd_d  = '0;
                    iterCnt_d  = '0;
                    state_d    = SHIFT;
                end
            end
            SHIFT: begin
                shiftReg_d = shiftedBin;
                workBcd_d  = shiftedBcd;
                if (iterCnt_q == LAST_ITER) begin
                    bcdOut_d = shiftedBcd;
                    done_d   = 1'b1;
                    state_d  = IDLE;
                end else begin
                    iterCnt_d = iterCnt_q + 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and datapath registers; reset abandons any conversion in flight
    // and clears the published result as well.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            shiftReg_q <= '0;
            workBcd_q  <= '0;
            iterCnt_q  <= '0;
            bcdOut_q   <= '0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            shiftReg_q <= shiftReg_d;
            workBcd_q  <= workBcd_d;
            iterCnt_q  <= iterCnt_d;
            bcdOut_q   <= bcdOut_d;
            done_q     <= done_d;
        end
    end

    assign busy    = (state_q == SHIFT);
    assign done    = done_q;
    assign bcd_out = bcdOut_q;

endmodule

// File: tb/tb_bin_to_bcd_seq.sv
// Randomized scoreboard bench for bin_to_bcd_seq.
module tb_bin_to_bcd_seq;

    localparam int W      = 8;
    localparam int DIGITS = 3;
    localparam int BCD_W  = 4 * DIGITS;

    logic             clk;
    logic             reset;
    logic             start;
    logic [W-1:0]     bin_in;
    logic             busy;
    logic             done;
    logic [BCD_W-1:0] bcd_out;

    typedef struct {
        logic [BCD_W-1:0] bcd;
        int               acceptCycle;
    } exp_t;

    exp_t             pending[$];
    logic [BCD_W-1:0] lastBcd;
    int               cycleCnt;
    int               checksTotal;
    int               checksPassed;
    int               doneCount;
    int               pushCount;
    int               abortCount;
    int               lastDoneCycle;
    int               prevDoneCycle;
    logic             checkEn;

    bin_to_bcd_seq #(.W(W), .DIGITS(DIGITS)) dut (
        .clk     (clk),
        .reset   (reset),
        .start   (start),
        .bin_in  (bin_in),
        .busy    (busy),
        .done    (done),
        .bcd_out (bcd_out)
    );

    // Free-running clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Reject a parameter set whose digits cannot hold the largest input.
    initial begin
        longint maxBin;
        longint pow10;
        maxBin = (longint'(1) << W) - 1;
        pow10  = 1;
        for (int d = 0; d < DIGITS; d++) pow10 = pow10 * 10;
        if (pow10 <= maxBin) begin
            $display("[TB] FAIL paramLegality: 10^%0d=%0d does not exceed %0d", DIGITS, pow10, maxBin);
            $fatal(1, "[TB] illegal W/DIGITS");
        end
    end

    // Reference conversion: plain decimal digit extraction.
    function automatic logic [BCD_W-1:0] refBcd(input int value);
        logic [BCD_W-1:0] res;
        int               rem;
        res = '0;
        rem = value;
        for (int d = 0; d < DIGITS; d++) begin
            res[4*d +: 4] = 4'(rem % 10);
            rem = rem / 10;
        end
        return res;
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checksTotal++;
        if (actual === expected) begin
            checksPassed++;
        end else begin
            $display("[TB] FAIL %s: got %0h, expected %0h (cycle %0d)", name, actual, expected, cycleCnt);
        end
    endtask

    task automatic pushExpected(input int value);
        exp_t e;
        e.bcd         = refBcd(value);
        e.acceptCycle = cycleCnt;
        pending.push_back(e);
        pushCount++;
    endtask

    // Issue one request from idle, wait out the conversion, then idle for gap cycles.
    task automatic applyStimulus(input int value, input int gap);
        start  = 1'b1;
        bin_in = W'(value);
        @(posedge clk); #1;
        pushExpected(value);
        start = 1'b0;
        repeat (W) @(posedge clk);
        #1;
        repeat (gap) begin
            @(posedge clk); #1;
        end
    endtask

    // Cycle counter; a reset edge drops every outstanding expectation.
    always @(posedge clk) begin
        cycleCnt <= cycleCnt + 1;
        if (reset) begin
            pending.delete();
            lastBcd = '0;
        end
    end

    // Monitor: compares the DUT against the scoreboard on every falling edge.
    always @(negedge clk) begin
        if (checkEn) begin
            logic expBusy;
            expBusy = (pending.size() > 0) && ((cycleCnt - pending[0].acceptCycle) < W);
            checkOutput("doneBusyExclusive", 32'(done & busy), 32'd0);
            checkOutput("busy", 32'(busy), 32'(expBusy));
            if (done) begin
                doneCount++;
                if (pending.size() == 0) begin
                    checkOutput("unexpectedDone", 32'd1, 32'd0);
                end else begin
                    exp_t e;
                    e = pending.pop_front();
                    checkOutput("bcdValue", 32'(bcd_out), 32'(e.bcd));
                    checkOutput("latency", 32'(cycleCnt - e.acceptCycle), 32'(W));
                    for (int d = 0; d < DIGITS; d++) begin
                        checkOutput("digitRange", 32'(bcd_out[4*d +: 4] <= 4'd9), 32'd1);
                    end
                    lastBcd = e.bcd;
                end
                prevDoneCycle = lastDoneCycle;
                lastDoneCycle = cycleCnt;
            end else begin
                checkOutput("bcdHold", 32'(bcd_out), 32'(lastBcd));
                if (pending.size() > 0 && (cycleCnt - pending[0].acceptCycle) >= W) begin
                    checkOutput("missingDone", 32'd0, 32'd1);
                    void'(pending.pop_front());
                end
            end
        end
    end

    // Hard time limit so the run always ends.
    initial begin
        #2000000;
        $display("[TB] FAIL timeout: simulation did not finish, checks %0d", checksTotal);
        $fatal(1, "[TB] timeout");
    end

    // Directed scenarios followed by an exhaustive randomized sweep.
    initial begin
        int doneBefore;
        cycleCnt      = 0;
        checksTotal   = 0;
        checksPassed  = 0;
        doneCount     = 0;
        pushCount     = 0;
        abortCount    = 0;
        lastDoneCycle = 0;
        prevDoneCycle = 0;
        lastBcd       = '0;
        checkEn       = 1'b0;
        reset         = 1'b1;
        start         = 1'b0;
        bin_in        = '0;

        repeat (2) @(posedge clk);
        #1;
        reset   = 1'b0;
        checkEn = 1'b1;
        checkOutput("resetBusy", 32'(busy), 32'd0);
        checkOutput("resetDone", 32'(done), 32'd0);
        checkOutput("resetBcd", 32'(bcd_out), 32'd0);

        $display("[TB] zero and max values");
        applyStimulus(0, 1);
        applyStimulus(255, 1);
        applyStimulus(15, 1);

        $display("[TB] start while busy is ignored");
        doneBefore = doneCount;
        start  = 1'b1;
        bin_in = W'(99);
        @(posedge clk); #1;
        pushExpected(99);
        start = 1'b0;
        repeat (3) begin
            @(posedge clk); #1;
        end
        start  = 1'b1;
        bin_in = W'(7);
        @(posedge clk); #1;
        start = 1'b0;
        repeat (W + 6) begin
            @(posedge clk); #1;
        end
        checkOutput("ignoredStartDones", 32'(doneCount - doneBefore), 32'd1);
        checkOutput("ignoredStartBcd", 32'(bcd_out), 32'h099);

        $display("[TB] reset during a conversion");
        applyStimulus(42, 1);
        checkOutput("preResetBcd", 32'(bcd_out), 32'h042);
        doneBefore = doneCount;
        start  = 1'b1;
        bin_in = W'(200);
        @(posedge clk); #1;
        pushExpected(200);
        abortCount++;
        start = 1'b0;
        repeat (3) begin
            @(posedge clk); #1;
        end
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        checkOutput("abortBusy", 32'(busy), 32'd0);
        checkOutput("abortBcd", 32'(bcd_out), 32'd0);
        repeat (16) begin
            @(posedge clk); #1;
        end
        checkOutput("abortNoDone", 32'(doneCount - doneBefore), 32'd0);

        $display("[TB] back-to-back with start held");
        start  = 1'b1;
        bin_in = W'(128);
        @(posedge clk); #1;
        pushExpected(128);
        bin_in = W'(9);
        repeat (W + 1) @(posedge clk);
        #1;
        pushExpected(9);
        start = 1'b0;
        repeat (W) @(posedge clk);
        #1;
        @(posedge clk); #1;
        checkOutput("b2bSpacing", 32'(lastDoneCycle - prevDoneCycle), 32'(W + 1));
        checkOutput("b2bBcd", 32'(bcd_out), 32'h009);

        $display("[TB] exhaustive sweep with random gaps");
        for (int v = 0; v < (1 << W); v++) begin
            applyStimulus(v, int'($urandom_range(0, 3)));
        end
        repeat (2) begin
            @(posedge clk); #1;
        end

        checkOutput("pendingDrained", 32'(pending.size()), 32'd0);
        checkOutput("doneTotal", 32'(doneCount), 32'(pushCount - abortCount));

        $display("%0d/%0d checks passed", checksPassed, checksTotal);
        $finish;
    end

endmodule
